// File: rtl/updown_pkg.sv
// Shared constants and next-count arithmetic for the
// parametrised up/down counter.
package updown_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Returns {next[31:0], crossed, hit}; 33-bit math avoids overflow.
  function automatic logic [33:0] next_count(
    input logic [31:0] count,
    input logic [31:0] step,
    input logic        dir,
    input logic [31:0] max_val,
    input logic        sat
  );
    logic [32:0] c;
    logic [32:0] s;
    logic [32:0] m;
    logic [32:0] sum;
    logic [31:0] nxt;
    logic        crossed;
    logic        hit;
    c       = {1'b0, count};
    s       = {1'b0, step};
    m       = {1'b0, max_val};
    sum     = c + s;
    nxt     = count;
    crossed = 1'b0;
    hit     = 1'b0;
    if (step != '0) begin
      if (dir == DIR_UP) begin
        if (sum > m) begin
          crossed = 1'b1;
          nxt = sat ? max_val : 32'(sum - m - 33'd1);
        end else begin
          nxt = 32'(sum);
          hit = (sum == m);
        end
      end else begin
        if (s <= c) begin
          nxt = 32'(c - s);
          hit = (c == s);
        end else begin
          crossed = 1'b1;
          nxt = sat ? '0 : 32'(c + m + 33'd1 - s);
        end
      end
    end
    return {nxt, crossed, hit};
  endfunction

endpackage

// File: rtl/updown_step_calc.sv
// Combinational next-value and boundary detection
// for updown_counter_param.
module updown_step_calc
  import updown_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               STEP_W   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1,
  parameter int               SATURATE = 0
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic              up_down,
  output logic [WIDTH-1:0]  nxt,
  output logic              crossed,
  output logic              hit
);

  logic [33:0] res;
  logic        unused_res;

  always_comb begin
    res = next_count(32'(count), 32'(step), up_down,
                     32'(MAX_VAL), SATURATE == MODE_SAT);
  end

  assign nxt        = res[WIDTH+1:2];
  assign crossed    = res[1];
  assign hit        = res[0];
  assign unused_res = ^res;

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: wrap or saturate, variable
// step, load/clear, boundary pulse and sticky ovf/unf flags.
module updown_counter_param
  import updown_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1,
  parameter int               STEP_W   = 4,
  parameter int               SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              bnd_evt,
  output logic              ovf,
  output logic              unf,
  output logic              at_max,
  output logic              at_min
);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_clamp;
  logic             crossed;
  logic             hit;
  logic             sel_clr;
  logic             sel_ld;
  logic             sel_cnt;

  updown_step_calc #(
    .WIDTH    (WIDTH),
    .STEP_W   (STEP_W),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_calc (
    .count   (count),
    .step    (step),
    .up_down (up_down),
    .nxt     (nxt),
    .crossed (crossed),
    .hit     (hit)
  );

  // One-hot action select: clear > load > en.
  assign sel_clr = clear;
  assign sel_ld  = load & ~clear;
  assign sel_cnt = en & ~clear & ~load;

  assign load_clamp = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      bnd_evt <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      unique case (1'b1)
        sel_clr: begin
          count   <= '0;
          bnd_evt <= 1'b0;
        end
        sel_ld: begin
          count   <= load_clamp;
          bnd_evt <= 1'b0;
        end
        sel_cnt: begin
          count   <= nxt;
          bnd_evt <= crossed | hit;
        end
        default: bnd_evt <= 1'b0;
      endcase
      // Setting on the same edge wins over clr_flags.
      ovf <= (ovf & ~clr_flags)
           | (sel_cnt & up_down & crossed);
      unf <= (unf & ~clr_flags)
           | (sel_cnt & ~up_down & crossed);
    end
  end

  assign at_max = (count == MAX_VAL);
  assign at_min = (count == '0);

endmodule
